// File: rtl/uart_flash_cmd_ctrl.sv
// UART-to-flash command sequencer: collects framed commands from the
// receive byte stream, runs one flash op per frame, returns one response byte.
module uart_flash_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  OP_READ     = 8'h01,
    parameter logic [7:0]  OP_PROG     = 8'h02,
    parameter logic [7:0]  OP_ERASE    = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_flag,
    input  logic [7:0]  rx_data,
    output logic        fl_req,
    output logic [1:0]  fl_op,
    output logic [23:0] fl_addr,
    output logic [7:0]  fl_wdata,
    input  logic        fl_ack,
    input  logic [7:0]  fl_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overrun
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] FOP_READ  = 2'b01;
    localparam logic [1:0] FOP_PROG  = 2'b10;
    localparam logic [1:0] FOP_ERASE = 2'b11;

    localparam logic [7:0] RSP_OK  = 8'hAA;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ISSUE,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_state;
    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo;
    logic          r_fl_req;
    logic          w_fl_req;
    logic [1:0]    r_fl_op;
    logic [1:0]    w_fl_op;
    logic [23:0]   r_fl_addr;
    logic [23:0]   w_fl_addr;
    logic [7:0]    r_fl_wdata;
    logic [7:0]    w_fl_wdata;
    logic          r_tx_valid;
    logic          w_tx_valid;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data;
    logic          r_overrun;
    logic          w_overrun;
    logic          w_in_op;

    assign w_in_op = (r_state == S_ISSUE) ||
                     (r_state == S_WAIT_ACK) ||
                     (r_state == S_RESP);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_tmo      = '0;
        w_fl_req   = r_fl_req;
        w_fl_op    = r_fl_op;
        w_fl_addr  = r_fl_addr;
        w_fl_wdata = r_fl_wdata;
        w_tx_valid = r_tx_valid;
        w_tx_data  = r_tx_data;
        w_overrun  = r_overrun | (rx_flag & w_in_op);

        unique case (r_state)
            S_IDLE: begin
                if (rx_flag) begin
                    w_cnt      = 2'd0;
                    w_fl_wdata = 8'h00;
                    if (rx_data == OP_READ) begin
                        w_fl_op = FOP_READ;
                        w_state = S_ADDR;
                    end else if (rx_data == OP_PROG) begin
                        w_fl_op = FOP_PROG;
                        w_state = S_ADDR;
                    end else if (rx_data == OP_ERASE) begin
                        w_fl_op = FOP_ERASE;
                        w_state = S_ADDR;
                    end else begin
                        w_tx_data  = RSP_ERR;
                        w_tx_valid = 1'b1;
                        w_state    = S_RESP;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_flag) begin
                    if (r_state == S_DATA) begin
                        w_fl_wdata = rx_data;
                        w_state    = S_ISSUE;
                    end else begin
                        w_fl_addr = {r_fl_addr[15:0], rx_data};
                        w_cnt     = r_cnt + 2'd1;
                        if (r_cnt == 2'd2) begin
                            w_state = (r_fl_op == FOP_PROG) ? S_DATA : S_ISSUE;
                        end
                    end
                end else if (r_tmo == TMO_LAST) begin
                    // Stalled sender: drop the partial frame without a response
                    w_state = S_IDLE;
                end else begin
                    w_tmo = r_tmo + 1'b1;
                end
            end
            S_ISSUE: begin
                w_fl_req = 1'b1;
                w_state  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (fl_ack) begin
                    w_fl_req   = 1'b0;
                    w_tx_data  = (r_fl_op == FOP_READ) ? fl_rdata : RSP_OK;
                    w_tx_valid = 1'b1;
                    w_state    = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_tmo      <= '0;
            r_fl_req   <= 1'b0;
            r_fl_op    <= 2'b00;
            r_fl_addr  <= 24'h0;
            r_fl_wdata <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_tmo      <= w_tmo;
            r_fl_req   <= w_fl_req;
            r_fl_op    <= w_fl_op;
            r_fl_addr  <= w_fl_addr;
            r_fl_wdata <= w_fl_wdata;
            r_tx_valid <= w_tx_valid;
            r_tx_data  <= w_tx_data;
            r_overrun  <= w_overrun;
        end
    end

    assign fl_req   = r_fl_req;
    assign fl_op    = r_fl_op;
    assign fl_addr  = r_fl_addr;
    assign fl_wdata = r_fl_wdata;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != S_IDLE);
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_flash_cmd_ctrl.sv
// Bench for uart_flash_cmd_ctrl: directed frames plus randomized frames
// checked against a transaction-level model of the command protocol.
module tb_uart_flash_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_flag = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        fl_req;
    logic [1:0]  fl_op;
    logic [23:0] fl_addr;
    logic [7:0]  fl_wdata;
    logic        fl_ack = 1'b0;
    logic [7:0]  fl_rdata = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_ovr = 1'b0;

    uart_flash_cmd_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_flag  (rx_flag),
        .rx_data  (rx_data),
        .fl_req   (fl_req),
        .fl_op    (fl_op),
        .fl_addr  (fl_addr),
        .fl_wdata (fl_wdata),
        .fl_ack   (fl_ack),
        .fl_rdata (fl_rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_flag = 1'b1;
        rx_data = b;
        tick();
        rx_flag = 1'b0;
    endtask

    function automatic bit is_cmd(input logic [7:0] op);
        return (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
    endfunction

    function automatic logic [1:0] model_flop(input logic [7:0] op);
        case (op)
            8'h01:   return 2'b01;
            8'h02:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [7:0] model_resp(input logic [7:0] op,
                                              input logic [7:0] rd);
        if (!is_cmd(op)) return 8'hEE;
        return (op == 8'h01) ? rd : 8'hAA;
    endfunction

    // One full frame; inj drops a stray byte into the flash-op phase
    task automatic run_frame(input logic [7:0] op, input logic [23:0] addr,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input int gapmax, input int ackdly,
                             input int rdydly, input bit inj);
        logic [7:0] exp_tx;
        exp_tx = model_resp(op, rd);
        chk("idle_busy", busy, 0);
        send(op);
        if (is_cmd(op)) begin
            for (int i = 2; i >= 0; i--) begin
                idle($urandom_range(0, gapmax));
                send(addr[i*8 +: 8]);
            end
            if (op == 8'h02) begin
                idle($urandom_range(0, gapmax));
                send(wd);
            end
            chk("issue_noreq", fl_req, 0);
            chk("issue_busy", busy, 1);
            tick();
            chk("req", fl_req, 1);
            chk("fl_op", fl_op, model_flop(op));
            chk("fl_addr", fl_addr, addr);
            chk("fl_wdata", fl_wdata, (op == 8'h02) ? wd : 8'h00);
            for (int i = 0; i < ackdly; i++) begin
                if (inj && i == 0) begin
                    rx_flag = 1'b1;
                    rx_data = 8'h55;
                    exp_ovr = 1'b1;
                end
                tick();
                rx_flag = 1'b0;
                chk("req_hold", fl_req, 1);
                chk("addr_hold", fl_addr, addr);
            end
            fl_ack   = 1'b1;
            fl_rdata = rd;
            if (inj && ackdly == 0) begin
                rx_flag = 1'b1;
                rx_data = 8'h55;
                exp_ovr = 1'b1;
            end
            tick();
            fl_ack   = 1'b0;
            rx_flag  = 1'b0;
            fl_rdata = 8'($urandom);
            chk("req_drop", fl_req, 0);
        end
        chk("tx_valid", tx_valid, 1);
        chk("tx_data", tx_data, exp_tx);
        for (int i = 0; i < rdydly; i++) begin
            tick();
            chk("tx_valid_hold", tx_valid, 1);
            chk("tx_data_hold", tx_data, exp_tx);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("tx_done", tx_valid, 0);
        chk("done_busy", busy, 0);
        chk("overrun", overrun, exp_ovr);
    endtask

    task automatic run_timeout(input logic [7:0] op, input int nbytes);
        send(op);
        for (int i = 0; i < nbytes; i++) begin
            send(8'($urandom));
        end
        for (int i = 0; i < 22; i++) begin
            tick();
            chk("tmo_noreq", fl_req, 0);
            chk("tmo_notx", tx_valid, 0);
        end
        chk("tmo_busy", busy, 0);
    endtask

    task automatic run_random(input int n, input bit allow_inj);
        int k;
        logic [7:0] op;
        for (int t = 0; t < n; t++) begin
            k = $urandom_range(0, 9);
            if (k < 7) begin
                op = 8'($urandom_range(1, 3));
            end else begin
                op = 8'($urandom_range(4, 255));
                if ($urandom_range(0, 1) == 1) op = 8'h00;
            end
            if (k == 9) begin
                op = 8'($urandom_range(1, 3));
                run_timeout(op, $urandom_range(0, (op == 8'h02) ? 3 : 2));
            end else begin
                run_frame(op, 24'($urandom), 8'($urandom), 8'($urandom),
                          12, $urandom_range(0, 5), $urandom_range(0, 4),
                          allow_inj && ($urandom_range(0, 3) == 0));
            end
        end
    endtask

    initial begin
        idle(2);
        chk("rst_req", fl_req, 0);
        chk("rst_op", fl_op, 0);
        chk("rst_addr", fl_addr, 0);
        chk("rst_wdata", fl_wdata, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        tick();

        run_frame(8'h01, 24'h123456, 8'h00, 8'h5A, 0, 2, 3, 1'b0);
        run_frame(8'h02, 24'h000010, 8'hC3, 8'h11, 0, 1, 0, 1'b0);
        run_frame(8'h7F, 24'h0, 8'h00, 8'h00, 0, 0, 2, 1'b0);
        run_frame(8'h03, 24'h010000, 8'h00, 8'h22, 0, 3, 1, 1'b0);

        send(8'h01);
        send(8'h12);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("tmo_noreq", fl_req, 0);
        end
        chk("tmo_busy", busy, 0);
        chk("tmo_notx", tx_valid, 0);
        run_frame(8'h01, 24'h000000, 8'h00, 8'h3C, 0, 0, 0, 1'b0);

        fl_ack   = 1'b1;
        tx_ready = 1'b1;
        tick();
        fl_ack   = 1'b0;
        tx_ready = 1'b0;
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_txv", tx_valid, 0);

        run_random(40, 1'b0);

        run_frame(8'h01, 24'hABCDEF, 8'h00, 8'h96, 0, 2, 20, 1'b1);
        run_frame(8'h03, 24'h00FF00, 8'h00, 8'h00, 0, 0, 1, 1'b0);
        run_random(120, 1'b1);

        send(8'h01);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        tick();
        tick();
        chk("pre_rst_req", fl_req, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_ovr = 1'b0;
        chk("midrst_req", fl_req, 0);
        chk("midrst_addr", fl_addr, 0);
        chk("midrst_op", fl_op, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovr", overrun, 0);
        fl_ack   = 1'b1;
        fl_rdata = 8'h77;
        tick();
        fl_ack   = 1'b0;
        chk("late_ack_txv", tx_valid, 0);
        chk("late_ack_busy", busy, 0);
        run_frame(8'h02, 24'hFFFFFF, 8'h5E, 8'h00, 3, 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
